// File: rtl/sysctrl_pkg.sv
// Shared definitions for the game system controller: state encodings and default key codes.
package sysctrl_pkg;

    typedef enum logic [2:0] {
        S_RESET       = 3'd0,
        S_IDLE        = 3'd1,
        S_WAIT_KEY    = 3'd2,
        S_GAME_ACTIVE = 3'd3,
        S_PAUSED      = 3'd4,
        S_GAME_OVER   = 3'd5
    } state_e;

    localparam int unsigned STATE_W_DEF   = 8;
    localparam logic [3:0]  KEY_PAUSE_DEF = 4'hE;
    localparam logic [3:0]  KEY_ABORT_DEF = 4'hF;

endpackage

// File: rtl/sysctrl_timer.sv
// Saturating up-counter with synchronous clear, count enable and terminal-count compare.
module sysctrl_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [Width-1:0] limit_i,
    output logic             tc_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {Width{1'b1}})) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/game_system_controller.sv
// Top-level system FSM: game selection, start, pause/resume, abort and game-over hold.
// Optional inactivity auto-pause in GAME_ACTIVE is enabled by defining SYSCTRL_WATCHDOG_EN.
module game_system_controller
    import sysctrl_pkg::*;
#(
    parameter int unsigned     KEY_W          = 4,
    parameter int unsigned     STATE_W        = STATE_W_DEF,
    parameter int unsigned     NUM_GAMES      = 4,
    parameter logic [KEY_W-1:0] KEY_PAUSE     = KEY_W'(KEY_PAUSE_DEF),
    parameter logic [KEY_W-1:0] KEY_ABORT     = KEY_W'(KEY_ABORT_DEF),
    parameter int unsigned     PAUSE_TIMEOUT  = 1000,
    parameter int unsigned     OVER_HOLD      = 50,
    parameter int unsigned     ACTIVE_TIMEOUT = 5000,
    localparam int unsigned    SEL_W          = (NUM_GAMES > 1) ? $clog2(NUM_GAMES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_valid,
    input  logic [KEY_W-1:0]   key_code,
    input  logic               game_done,
    output logic [SEL_W-1:0]   game_sel,
    output logic               game_start,
    output logic               game_enable,
    output logic               paused,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned TMR_MAX_PO = (PAUSE_TIMEOUT > OVER_HOLD) ? PAUSE_TIMEOUT : OVER_HOLD;
    localparam int unsigned TMR_MAX    = (TMR_MAX_PO > ACTIVE_TIMEOUT) ? TMR_MAX_PO : ACTIVE_TIMEOUT;
    localparam int unsigned TMR_W      = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] PT_TC = TMR_W'(PAUSE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] OH_TC = TMR_W'(OVER_HOLD - 1);
`ifdef SYSCTRL_WATCHDOG_EN
    localparam logic [TMR_W-1:0] AT_TC = TMR_W'(ACTIVE_TIMEOUT - 1);
`endif
    localparam logic [KEY_W-1:0] NUM_GAMES_K = KEY_W'(NUM_GAMES);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             start_q, start_d;
    logic             enable_q, paused_q;

    logic             tmr_clr, tmr_en, tmr_tc;
    logic [TMR_W-1:0] tmr_limit;

    logic key_sel, key_pause, key_abort;

    assign key_sel   = key_valid && (key_code != '0) && (key_code <= NUM_GAMES_K);
    assign key_pause = key_valid && (key_code == KEY_PAUSE);
    assign key_abort = key_valid && (key_code == KEY_ABORT);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        start_d   = 1'b0;
        tmr_clr   = 1'b1;
        tmr_en    = 1'b0;
        tmr_limit = '0;

        unique case (state_q)
            S_RESET:    state_d = S_IDLE;
            S_IDLE:     state_d = S_WAIT_KEY;
            S_WAIT_KEY: begin
                if (key_sel) begin
                    state_d = S_GAME_ACTIVE;
                    sel_d   = SEL_W'(key_code - KEY_W'(1));
                    start_d = 1'b1;
                end
            end
            S_GAME_ACTIVE: begin
`ifdef SYSCTRL_WATCHDOG_EN
                // Any key restarts the inactivity count
                tmr_clr   = key_valid;
                tmr_en    = 1'b1;
                tmr_limit = AT_TC;
`endif
                if (game_done || key_abort) begin
                    state_d = S_GAME_OVER;
                end else if (key_pause) begin
                    state_d = S_PAUSED;
`ifdef SYSCTRL_WATCHDOG_EN
                end else if (!key_valid && tmr_tc) begin
                    state_d = S_PAUSED;
`endif
                end
            end
            S_PAUSED: begin
                tmr_clr   = 1'b0;
                tmr_en    = 1'b1;
                tmr_limit = PT_TC;
                if (key_abort) begin
                    state_d = S_GAME_OVER;
                end else if (key_pause) begin
                    state_d = S_GAME_ACTIVE;
                end else if (tmr_tc) begin
                    state_d = S_GAME_OVER;
                end
            end
            S_GAME_OVER: begin
                tmr_clr   = 1'b0;
                tmr_en    = 1'b1;
                tmr_limit = OH_TC;
                if (tmr_tc) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_RESET;
        endcase

        // Timer always starts from zero in the first cycle of a new state
        if (state_d != state_q) begin
            tmr_clr = 1'b1;
        end
    end

    sysctrl_timer #(
        .Width (TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .limit_i (tmr_limit),
        .tc_o    (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RESET;
            sel_q    <= '0;
            start_q  <= 1'b0;
            enable_q <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            start_q  <= start_d;
            enable_q <= (state_d == S_GAME_ACTIVE);
            paused_q <= (state_d == S_PAUSED);
        end
    end

    assign game_sel    = sel_q;
    assign game_start  = start_q;
    assign game_enable = enable_q;
    assign paused      = paused_q;
    assign state       = STATE_W'(state_q);

endmodule

// File: tb/tb_game_system_controller.sv
// Self-checking bench for game_system_controller: directed steps then random keys vs a reference model.
module tb_game_system_controller;

    localparam int KEY_W = 4;
    localparam int STATE_W = 8;
    localparam int NG = 4;
    localparam int PT = 16;
    localparam int OH = 4;
    localparam int AT = 8;

    logic               clk;
    logic               rst_n;
    logic               key_valid;
    logic [KEY_W-1:0]   key_code;
    logic               game_done;
    logic [1:0]         game_sel;
    logic               game_start;
    logic               game_enable;
    logic               paused;
    logic [STATE_W-1:0] state;

    int errors = 0;
    int checks = 0;

    // Reference model: state name as an integer, dwell = cycles spent so far in the state,
    // quiet = cycles in GAME_ACTIVE since entry or last key.
    int m_state, m_sel, m_dwell, m_quiet;
    bit m_start;

    game_system_controller #(
        .KEY_W          (KEY_W),
        .STATE_W        (STATE_W),
        .NUM_GAMES      (NG),
        .KEY_PAUSE      (4'hE),
        .KEY_ABORT      (4'hF),
        .PAUSE_TIMEOUT  (PT),
        .OVER_HOLD      (OH),
        .ACTIVE_TIMEOUT (AT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .game_done   (game_done),
        .game_sel    (game_sel),
        .game_start  (game_start),
        .game_enable (game_enable),
        .paused      (paused),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_sel = 0; m_dwell = 0; m_quiet = 0; m_start = 1'b0;
    endtask

    task automatic model_clock(input bit kv, input int kc, input bit gd);
        int nxt;
        nxt = m_state;
        m_start = 1'b0;
        case (m_state)
            0: nxt = 1;
            1: nxt = 2;
            2: if (kv && kc >= 1 && kc <= NG) begin
                nxt = 3; m_sel = kc - 1; m_start = 1'b1;
            end
            3: begin
                if (gd || (kv && kc == 15)) nxt = 5;
                else if (kv && kc == 14) nxt = 4;
`ifdef SYSCTRL_WATCHDOG_EN
                else if (kv) m_quiet = 0;
                else if (m_quiet + 1 == AT) nxt = 4;
                else m_quiet++;
`endif
            end
            4: begin
                if (kv && kc == 15) nxt = 5;
                else if (kv && kc == 14) nxt = 3;
                else if (m_dwell + 1 == PT) nxt = 5;
            end
            5: if (m_dwell + 1 == OH) nxt = 1;
            default: nxt = 0;
        endcase
        if (nxt != m_state) begin
            m_dwell = 0;
            m_quiet = 0;
        end else begin
            m_dwell++;
        end
        m_state = nxt;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 32'(state), 32'(m_state));
        chk({tag, ".sel"}, 32'(game_sel), 32'(m_sel));
        chk({tag, ".start"}, 32'(game_start), 32'(m_start));
        chk({tag, ".enable"}, 32'(game_enable), 32'(m_state == 3));
        chk({tag, ".paused"}, 32'(paused), 32'(m_state == 4));
    endtask

    // Called at a falling edge: drive, clock, check 1 time unit later, return at next falling edge.
    task automatic step(input string tag, input bit kv, input int kc, input bit gd);
        key_valid = kv;
        key_code  = 4'(kc);
        game_done = gd;
        @(posedge clk);
        model_clock(kv, kc, gd);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 0, 1'b0);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        key_valid = 1'b0;
        key_code = '0;
        game_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Power-up sequence 0 -> 1 -> 2, then hold in WAIT_KEY
        idle("boot", 4);
        chk("boot.wait", 32'(state), 32'd2);

        // Out-of-range and control keys are ignored in WAIT_KEY
        step("wk_k0", 1'b1, 0, 1'b0);
        step("wk_k5", 1'b1, 5, 1'b0);
        step("wk_kE", 1'b1, 14, 1'b0);
        step("wk_kF", 1'b1, 15, 1'b0);

        // Launch game 3
        step("launch3", 1'b1, 3, 1'b0);
        chk("launch3.sel_abs", 32'(game_sel), 32'd2);
        chk("launch3.start_abs", 32'(game_start), 32'd1);
        step("launch3_next", 1'b1, 1, 1'b0);

        // Pause, resume, pause then time out
        step("pause", 1'b1, 14, 1'b0);
        step("resume", 1'b1, 14, 1'b0);
        chk("resume.nostart", 32'(game_start), 32'd0);
        step("pause2", 1'b1, 14, 1'b0);
        step("pause_gd", 1'b0, 0, 1'b1);
        idle("pause_to", PT - 1);
        chk("pause_to.over", 32'(state), 32'd5);
        idle("over_hold", OH + 1);
        chk("over_hold.wait", 32'(state), 32'd2);

        // game_done beats PAUSE in the same cycle
        step("launch2", 1'b1, 2, 1'b0);
        step("done_pause", 1'b1, 14, 1'b1);
        chk("done_pause.over", 32'(state), 32'd5);
        idle("over2", OH + 1);

        // Abort from paused, then relaunch and reset asynchronously while paused
        step("launch1", 1'b1, 1, 1'b0);
        step("pause3", 1'b1, 14, 1'b0);
        step("abort", 1'b1, 15, 1'b0);
        idle("over3", OH + 1);
        step("launch4", 1'b1, 4, 1'b0);
        step("pause4", 1'b1, 14, 1'b0);
        idle("paused4", 3);
        async_reset("async_rst");
        idle("reboot", 3);

        // Inactivity in GAME_ACTIVE (auto-pause only when the watchdog is built in)
        step("launch_wd", 1'b1, 2, 1'b0);
        idle("active_quiet", AT + 2);
        step("abort_wd", 1'b1, 15, 1'b0);
        idle("over_wd", OH + 1);

        // Random phase
        for (int i = 0; i < 600; i++) begin
            bit kv;
            bit gd;
            int kc;
            kv = ($urandom_range(0, 3) == 0);
            kc = $urandom_range(0, 15);
            gd = ($urandom_range(0, 23) == 0);
            step("rand", kv, kc, gd);
            if (i == 300) async_reset("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
